// File: rtl/video_pkg.sv
// Shared video pipeline types and widths used by the assembler, filter and line-buffer stages.
package video_pkg;

  localparam int HCOUNT_W = 8;
  localparam int VCOUNT_W = 9;

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    LINE_WAIT = 2'd1,
    BYTE_HI   = 2'd2,
    BYTE_LO   = 2'd3
  } asm_state_t;

endpackage

// File: rtl/camera_pixel_assembler_if.sv
// Camera byte stream in, tagged RGB565 pixel strobe out.
interface camera_pixel_assembler_if;

  logic                          camera_pclk_in;
  logic                          camera_hs_in;
  logic                          camera_vs_in;
  logic [7:0]                    camera_data_in;
  logic                          data_valid_out;
  logic [15:0]                   pixel_data_out;
  logic [video_pkg::HCOUNT_W-1:0] hcount_out;
  logic [video_pkg::VCOUNT_W-1:0] vcount_out;

  modport master (
    output camera_pclk_in, camera_hs_in, camera_vs_in, camera_data_in,
    input  data_valid_out, pixel_data_out, hcount_out, vcount_out
  );

  modport slave (
    input  camera_pclk_in, camera_hs_in, camera_vs_in, camera_data_in,
    output data_valid_out, pixel_data_out, hcount_out, vcount_out
  );

endinterface

// File: rtl/edge_detect.sv
// One-cycle-delayed copy of a sampled level plus rise/fall pulses against that copy.
module edge_detect (
  input  logic clk_in,
  input  logic rst_in,
  input  logic d,
  output logic prev,
  output logic rise,
  output logic fall
);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) prev <= 1'b0;
    else        prev <= d;
  end

  assign rise = d & ~prev;
  assign fall = ~d & prev;

endmodule

// File: rtl/camera_pixel_assembler.sv
// Camera byte-serial RGB565 to one tagged 16-bit pixel per strobe.
// Optional short-line counter port: define CAMERA_ASSEMBLER_ERRCNT_EN.
module camera_pixel_assembler
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 240,
  parameter int V_ACTIVE = 320
) (
  input  logic clk_in,
  input  logic rst_in,
  camera_pixel_assembler_if.slave cam
`ifdef CAMERA_ASSEMBLER_ERRCNT_EN
  ,
  output logic [7:0] short_line_count_out
`endif
);

  // state     | meaning
  // SYNC_WAIT | no frame start seen since reset, everything ignored
  // LINE_WAIT | between lines, next qualified pclk edge is a high byte
  // BYTE_HI   | in a line, expecting the high byte of a pair
  // BYTE_LO   | in a line, high byte held, expecting the low byte

  // One extra bit so col/row can saturate at H_ACTIVE=256 / V_ACTIVE=512.
  localparam int COL_W = HCOUNT_W + 1;
  localparam int ROW_W = VCOUNT_W + 1;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(H_ACTIVE);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(V_ACTIVE);

  logic       pclk_s, hs_s, vs_s;
  logic [7:0] data_s;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pclk_s <= 1'b0;
      hs_s   <= 1'b0;
      vs_s   <= 1'b0;
      data_s <= '0;
    end else begin
      pclk_s <= cam.camera_pclk_in;
      hs_s   <= cam.camera_hs_in;
      vs_s   <= cam.camera_vs_in;
      data_s <= cam.camera_data_in;
    end
  end

  logic pclk_prev, pclk_rise, pclk_fall;
  logic hs_prev, hs_rise, hs_fall;
  logic vs_prev, vs_rise, vs_fall;

  edge_detect u_pclk_edge (.clk_in, .rst_in, .d(pclk_s), .prev(pclk_prev), .rise(pclk_rise), .fall(pclk_fall));
  edge_detect u_hs_edge   (.clk_in, .rst_in, .d(hs_s),   .prev(hs_prev),   .rise(hs_rise),   .fall(hs_fall));
  edge_detect u_vs_edge   (.clk_in, .rst_in, .d(vs_s),   .prev(vs_prev),   .rise(vs_rise),   .fall(vs_fall));

  logic unused_edges;
  assign unused_edges = ^{pclk_prev, pclk_fall, hs_prev, hs_rise, vs_prev, vs_fall};

  asm_state_t       state, state_nxt;
  logic [COL_W-1:0] col, col_nxt;
  logic [ROW_W-1:0] row, row_nxt;
  logic [7:0]       hi, hi_nxt;
  logic             emit;
  logic             in_line;

  assign in_line = (state == BYTE_HI) || (state == BYTE_LO);

  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    hi_nxt    = hi;
    emit      = 1'b0;
    if (vs_rise) begin
      col_nxt   = '0;
      row_nxt   = '0;
      state_nxt = LINE_WAIT;
    end else if (state != SYNC_WAIT) begin
      // An hs_fall owns the cycle, so a coincident pclk edge is dropped.
      if (hs_fall) begin
        if (in_line) begin
          hi_nxt    = '0;
          col_nxt   = '0;
          row_nxt   = (row == ROW_MAX) ? row : row + ROW_W'(1);
          state_nxt = LINE_WAIT;
        end
      end else if (pclk_rise && hs_s) begin
        case (state)
          LINE_WAIT, BYTE_HI: begin
            hi_nxt    = data_s;
            state_nxt = BYTE_LO;
          end
          BYTE_LO: begin
            emit      = (col < COL_MAX) && (row < ROW_MAX);
            col_nxt   = (col == COL_MAX) ? col : col + COL_W'(1);
            state_nxt = BYTE_HI;
          end
          default: state_nxt = state;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state              <= SYNC_WAIT;
      col                <= '0;
      row                <= '0;
      hi                 <= '0;
      cam.data_valid_out <= 1'b0;
      cam.pixel_data_out <= '0;
      cam.hcount_out     <= '0;
      cam.vcount_out     <= '0;
    end else begin
      state              <= state_nxt;
      col                <= col_nxt;
      row                <= row_nxt;
      hi                 <= hi_nxt;
      cam.data_valid_out <= emit;
      if (emit) begin
        cam.pixel_data_out <= {hi, data_s};
        cam.hcount_out     <= col[HCOUNT_W-1:0];
        cam.vcount_out     <= row[VCOUNT_W-1:0];
      end
    end
  end

`ifdef CAMERA_ASSEMBLER_ERRCNT_EN
  // A line is short if it ended before H_ACTIVE pixels or with an unpaired byte.
  logic short_line;
  assign short_line = (state != SYNC_WAIT) && !vs_rise && hs_fall && in_line &&
                      ((col < COL_MAX) || (state == BYTE_LO));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)                                        short_line_count_out <= '0;
    else if (vs_rise)                                  short_line_count_out <= '0;
    else if (short_line && short_line_count_out != 8'hff) short_line_count_out <= short_line_count_out + 8'd1;
  end
`endif

endmodule

// File: tb/tb_camera_pixel_assembler.sv
// Scoreboard bench for camera_pixel_assembler: randomized camera timing and bytes vs a pixel-pair model.
module tb_camera_pixel_assembler;

  localparam int H = 240;
  localparam int V = 320;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;

  camera_pixel_assembler_if bus ();

`ifdef CAMERA_ASSEMBLER_ERRCNT_EN
  logic [7:0] short_cnt;
  camera_pixel_assembler #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .cam(bus), .short_line_count_out(short_cnt));
`else
  camera_pixel_assembler #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .cam(bus));
`endif

  always #5 clk_in = ~clk_in;

  int unsigned cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] pix;
    int          h;
    int          v;
    int unsigned at;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int strobes = 0;

  // Reference model of the frame: position, pending high byte, short-line tally.
  bit         m_started = 0;
  int         m_col = 0, m_row = 0, m_line_bytes = 0, m_short = 0;
  bit         m_have_hi = 0;
  logic [7:0] m_hi = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_short(input string name);
`ifdef CAMERA_ASSEMBLER_ERRCNT_EN
    check(name, 32'(short_cnt), 32'(m_short));
`else
    if (name.len() == 0) $display("empty check name");
`endif
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.camera_pclk_in = 1'b0;
    bus.camera_data_in = b;
    tick(int'($urandom_range(2, 3)));
    bus.camera_pclk_in = 1'b1;
    if (m_started && bus.camera_hs_in) begin
      m_line_bytes++;
      if (!m_have_hi) begin
        m_hi = b;
        m_have_hi = 1;
      end else begin
        if (m_col < H && m_row < V)
          exp_q.push_back('{pix: {m_hi, b}, h: m_col, v: m_row, at: cyc + 2});
        if (m_col < H) m_col++;
        m_have_hi = 0;
      end
    end
    tick(int'($urandom_range(2, 3)));
  endtask

  task automatic end_line();
    bus.camera_pclk_in = 1'b0;
    tick(2);
    bus.camera_hs_in = 1'b0;
    if (m_started && m_line_bytes > 0) begin
      if (m_col < H || m_have_hi) m_short = (m_short < 255) ? m_short + 1 : 255;
      m_col = 0;
      if (m_row < V) m_row++;
      m_have_hi = 0;
      m_line_bytes = 0;
    end
    tick(3);
  endtask

  task automatic send_line(input int n, input bit counting);
    bus.camera_hs_in = 1'b1;
    tick(2);
    for (int k = 0; k < n; k++) send_byte(counting ? 8'(k) : 8'($urandom));
    end_line();
  endtask

  task automatic frame_start();
    bus.camera_vs_in = 1'b1;
    tick(3);
    bus.camera_vs_in = 1'b0;
    m_started = 1;
    m_col = 0;
    m_row = 0;
    m_have_hi = 0;
    m_line_bytes = 0;
    m_short = 0;
    tick(2);
  endtask

  // Monitor: every strobe must match the oldest expected pixel, at the expected cycle.
  bit prev_valid = 0;
  always @(negedge clk_in) begin
    if (rst_in) begin
      prev_valid = 0;
    end else begin
      if (bus.data_valid_out) begin
        strobes++;
        check("strobe_gap", 32'(prev_valid), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe_h", 32'(bus.hcount_out), 32'hffff_ffff);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pixel", 32'(bus.pixel_data_out), 32'(e.pix));
          check("hcount", 32'(bus.hcount_out), 32'(e.h));
          check("vcount", 32'(bus.vcount_out), 32'(e.v));
          check("latency_cycle", cyc, e.at);
        end
      end
      prev_valid = bus.data_valid_out;
    end
  end

  initial begin
    int s0;
    bus.camera_pclk_in = 1'b0;
    bus.camera_hs_in   = 1'b0;
    bus.camera_vs_in   = 1'b0;
    bus.camera_data_in = '0;
    tick(3);
    check("reset_valid", 32'(bus.data_valid_out), 32'd0);
    check("reset_pixel", 32'(bus.pixel_data_out), 32'd0);
    check("reset_hcount", 32'(bus.hcount_out), 32'd0);
    check("reset_vcount", 32'(bus.vcount_out), 32'd0);
    check_short("reset_short");
    rst_in = 1'b0;
    tick(2);

    s0 = strobes;
    send_line(30, 1);
    send_line(12, 0);
    tick(4);
    check("preframe_strobes", 32'(strobes - s0), 32'd0);

    frame_start();
    s0 = strobes;
    send_line(480, 1);
    tick(4);
    check("line480_strobes", 32'(strobes - s0), 32'd240);
    check_short("short_full_line");

    frame_start();
    s0 = strobes;
    send_line(481, 1);
    check_short("short_after_row0");
    send_line(10, 1);
    check_short("short_after_row1");
    tick(4);
    check("line481_10_strobes", 32'(strobes - s0), 32'd245);

    frame_start();
    s0 = strobes;
    send_line(600, 1);
    tick(4);
    check("line600_strobes", 32'(strobes - s0), 32'd240);

    frame_start();
    s0 = strobes;
    for (int l = 0; l < 330; l++) send_line(4, 0);
    tick(4);
    check("frame330_strobes", 32'(strobes - s0), 32'd640);
    check_short("short_saturated");
    frame_start();
    s0 = strobes;
    send_line(6, 0);
    tick(4);
    check("restart_strobes", 32'(strobes - s0), 32'd3);

    for (int f = 0; f < 3; f++) begin
      frame_start();
      repeat ($urandom_range(2, 6)) send_line(int'($urandom_range(1, 40)), 0);
      tick(4);
      check_short("short_random");
    end

    // Reset while pixel 7's high byte is held.
    frame_start();
    bus.camera_hs_in = 1'b1;
    tick(2);
    for (int k = 0; k < 15; k++) send_byte(8'(k + 1));
    tick(3);
    #2 rst_in = 1'b1;
    #1;
    check("midline_rst_valid", 32'(bus.data_valid_out), 32'd0);
    check("midline_rst_pixel", 32'(bus.pixel_data_out), 32'd0);
    check("midline_rst_hcount", 32'(bus.hcount_out), 32'd0);
    check("midline_rst_vcount", 32'(bus.vcount_out), 32'd0);
    check("midline_rst_queue", 32'(exp_q.size()), 32'd0);
    bus.camera_hs_in   = 1'b0;
    bus.camera_pclk_in = 1'b0;
    m_started = 0;
    m_col = 0;
    m_row = 0;
    m_have_hi = 0;
    m_line_bytes = 0;
    m_short = 0;
    tick(2);
    rst_in = 1'b0;
    tick(2);
    s0 = strobes;
    send_line(20, 1);
    tick(4);
    check("post_rst_ignored", 32'(strobes - s0), 32'd0);
    frame_start();
    s0 = strobes;
    send_line(8, 1);
    tick(4);
    check("post_rst_strobes", 32'(strobes - s0), 32'd4);

    tick(6);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
